// File: rtl/viterbi_traceback_if.sv
`default_nettype none
// viterbi_traceback_if: per-step decision/metric input and decoded-block output
// bundle of the Viterbi traceback stage.
interface viterbi_traceback_if #(
  parameter int TB_LEN = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        dec;
  logic [7:0]        pm0;
  logic [7:0]        pm1;
  logic [7:0]        pm2;
  logic [7:0]        pm3;
  logic              out_valid;
  logic              out_ready;
  logic [TB_LEN-1:0] out_data;
  logic [1:0]        out_state;

  modport master (
    output in_valid, dec, pm0, pm1, pm2, pm3, out_ready,
    input  in_ready, out_valid, out_data, out_state
  );

  modport slave (
    input  in_valid, dec, pm0, pm1, pm2, pm3, out_ready,
    output in_ready, out_valid, out_data, out_state
  );
endinterface
`default_nettype wire

// File: rtl/viterbi_traceback.sv
`default_nettype none
// viterbi_traceback: buffers TB_LEN survivor-decision steps of a 4-state Viterbi
// decoder and traces back one step per cycle. Option macro: VITERBI_ZERO_TERM_EN.
module viterbi_traceback #(
  parameter int TB_LEN = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  viterbi_traceback_if.slave   bus
);
  localparam int              PW     = $clog2(TB_LEN);
  localparam logic [PW-1:0]   C_LAST = PW'(TB_LEN - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_mem [TB_LEN];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [1:0]        r_cur;
  logic [TB_LEN-1:0] r_out_data;
  logic [1:0]        r_out_state;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last_step;
  logic [3:0]        w_mem_dec;
  logic [1:0]        w_start;

  assign w_in_ready  = (r_state == FILL);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_last_step = (r_wr_ptr == C_LAST);
  assign w_mem_dec   = r_mem[r_rd_ptr];

`ifdef VITERBI_ZERO_TERM_EN
  logic w_unused_pm;
  assign w_unused_pm = ^{bus.pm0, bus.pm1, bus.pm2, bus.pm3};
  assign w_start     = 2'd0;
`else
  logic [1:0] w_lo_idx;
  logic [1:0] w_hi_idx;
  logic [7:0] w_lo_pm;
  logic [7:0] w_hi_pm;

  // Strict less-than at every stage keeps ties on the lower state index.
  always_comb begin
    w_lo_idx = 2'd0;
    w_lo_pm  = bus.pm0;
    w_hi_idx = 2'd2;
    w_hi_pm  = bus.pm2;
    if ($signed(bus.pm1) < $signed(bus.pm0)) begin
      w_lo_idx = 2'd1;
      w_lo_pm  = bus.pm1;
    end
    if ($signed(bus.pm3) < $signed(bus.pm2)) begin
      w_hi_idx = 2'd3;
      w_hi_pm  = bus.pm3;
    end
    w_start = ($signed(w_hi_pm) < $signed(w_lo_pm)) ? w_hi_idx : w_lo_idx;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:    if (w_accept && w_last_step) w_state_nxt = TRACE;
      TRACE:   if (r_rd_ptr == '0)          w_state_nxt = DONE;
      DONE:    if (bus.out_ready)           w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Decision memory carries no reset; the write pointer alone defines its content.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= bus.dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cur       <= 2'd0;
      r_out_data  <= '0;
      r_out_state <= 2'd0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            r_wr_ptr <= w_last_step ? '0 : r_wr_ptr + 1'b1;
            if (w_last_step) begin
              r_cur       <= w_start;
              r_out_state <= w_start;
              r_rd_ptr    <= C_LAST;
            end
          end
        end
        TRACE: begin
          r_out_data[r_rd_ptr] <= r_cur[1];
          r_cur                <= {r_cur[0], w_mem_dec[r_cur]};
          if (r_rd_ptr != '0) r_rd_ptr <= r_rd_ptr - 1'b1;
        end
        DONE: begin
          if (bus.out_ready) r_wr_ptr <= '0;
        end
        default: begin
          r_wr_ptr <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_state = r_out_state;
endmodule
`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
`default_nettype none
// tb_viterbi_traceback: directed-vector bench for viterbi_traceback with TB_LEN=16.
module tb_viterbi_traceback;
  localparam int TB_LEN = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [3:0] dv [TB_LEN];
  logic [7:0] lp [4];

  viterbi_traceback_if #(.TB_LEN(TB_LEN)) bus ();

  viterbi_traceback #(.TB_LEN(TB_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [3:0] d, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    for (int i = 0; i < TB_LEN; i++) dv[i] = d;
    lp[0] = p0; lp[1] = p1; lp[2] = p2; lp[3] = p3;
  endtask

  // Feeds dv[] back-to-back; returns on the negedge right after the last accept.
  task automatic feed_block(input string tag);
    int rdy_bad;
    rdy_bad = 0;
    for (int i = 0; i < TB_LEN; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b1) rdy_bad++;
      bus.in_valid = 1'b1;
      bus.dec      = dv[i];
      bus.pm0      = lp[0];
      bus.pm1      = lp[1];
      bus.pm2      = lp[2];
      bus.pm3      = lp[3];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_fill_ready"}, 32'(rdy_bad), 32'd0);
    check({tag, "_ready_drop"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd16);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_block(input string tag, input logic [15:0] exp_data, input logic [1:0] exp_st);
    feed_block(tag);
    wait_done(tag);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
    check({tag, "_state"}, 32'(bus.out_state), 32'(exp_st));
    handshake(tag);
  endtask

  logic [15:0] held_data;

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dec       = 4'h0;
    bus.pm0       = 8'h00;
    bus.pm1       = 8'h00;
    bus.pm2       = 8'h00;
    bus.pm3       = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_state", 32'(bus.out_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero path, signed metric -5 beats 10.
    fill_const(4'b0000, 8'hFB, 8'd10, 8'd10, 8'd10);
    run_block("zeros", 16'h0000, 2'd0);

    // All-ones path from state 3.
    fill_const(4'b1000, 8'd30, 8'd30, 8'd30, 8'hEC);
    run_block("ones", 16'hFFFF, 2'd3);

    // Single final one from state 2.
    fill_const(4'b0000, 8'd0, 8'd0, 8'hF8, 8'd0);
    run_block("final1", 16'h8000, 2'd2);

    // Start state 1 with dec[1]=1: states 1,3,2,0... -> bits 14,13 set.
    fill_const(4'b0010, 8'd5, 8'hFE, 8'd5, 8'd5);
    run_block("st1", 16'h6000, 2'd1);

    // Step 5 redirects state 0 to 1, then 2 at step 3 -> bit 3 set.
    fill_const(4'b0000, 8'hFF, 8'd0, 8'd0, 8'd0);
    dv[5] = 4'b0001;
    run_block("addr", 16'h0008, 2'd0);

    // Backpressure in DONE while pulsing in_valid with a poisoning pattern.
    fill_const(4'b1000, 8'd30, 8'd30, 8'd30, 8'hEC);
    feed_block("bp");
    wait_done("bp");
    held_data = bus.out_data;
    check("bp_data", 32'(held_data), 32'h0000FFFF);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0] ? 1'b0 : 1'b1;
      bus.dec      = 4'hF;
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_data", 32'(bus.out_data), 32'(held_data));
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    handshake("bp");

    // Tie break after backpressure: all metrics equal -> state 0.
    fill_const(4'b0000, 8'd7, 8'd7, 8'd7, 8'd7);
    run_block("tie", 16'h0000, 2'd0);

    // Reset asserted on the 4th trace cycle.
    fill_const(4'b1000, 8'd30, 8'd30, 8'd30, 8'hEC);
    feed_block("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_data", 32'(bus.out_data), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_state", 32'(bus.out_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_const(4'b0000, 8'd0, 8'd0, 8'hF8, 8'd0);
    run_block("post_rst", 16'h8000, 2'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
